// File: rtl/sprite_blit_sink.sv
// Sprite pixel-stream sink: offsets, clips and queues beats for the VGA plot interface.
// Optional build macro SPRITE_TRANSPARENCY_EN drops pixels whose color equals TRANSPARENT_COLOR.
module sprite_blit_sink #(
  parameter int unsigned WIDTH_X           = 4,
  parameter int unsigned WIDTH_Y           = 3,
  parameter int unsigned SCREEN_W          = 160,
  parameter int unsigned SCREEN_H          = 120,
  parameter int unsigned FIFO_DEPTH        = 4,
  parameter logic [2:0]  TRANSPARENT_COLOR = 3'b000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH_X-1:0] in_x,
  input  logic [WIDTH_Y-1:0] in_y,
  input  logic [2:0]         in_color,
  input  logic               in_last,
  input  logic [7:0]         origin_x,
  input  logic [6:0]         origin_y,
  output logic [7:0]         vga_x,
  output logic [6:0]         vga_y,
  output logic [2:0]         vga_color,
  output logic               vga_plot,
  input  logic               vga_ready,
  output logic               done,
  output logic [7:0]         drop_count
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned EntW = 20;

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e            state_q, state_d;
  logic              latch_origin;
  logic [7:0]        origin_x_q;
  logic [6:0]        origin_y_q;
  logic [7:0]        use_x;
  logic [6:0]        use_y;
  logic [8:0]        sx;
  logic [7:0]        sy;
  logic              keep;

  logic [EntW-1:0]   mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic              full, empty, push, pop;
  logic [EntW-1:0]   head, wr_entry;
  logic              head_keep, head_last;

  logic [7:0]        last_x_q;
  logic [6:0]        last_y_q;
  logic [2:0]        last_color_q;
  logic              done_q;
  logic [7:0]        drop_q;

  assign full      = (count_q == CntW'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign in_ready  = !reset && !full;
  assign push      = in_valid && in_ready;
  assign head      = mem_q[rd_ptr_q];
  assign head_keep = head[19];
  assign head_last = head[18];
  // Dropped entries leave the queue without waiting for the adapter.
  assign pop       = !empty && (!head_keep || vga_ready);

  // The first beat of a sprite uses the live origin; later beats use the latched copy.
  assign use_x = (state_q == StIdle) ? origin_x : origin_x_q;
  assign use_y = (state_q == StIdle) ? origin_y : origin_y_q;
  assign sx    = {1'b0, use_x} + 9'(in_x);
  assign sy    = {1'b0, use_y} + 8'(in_y);

`ifdef SPRITE_TRANSPARENCY_EN
  assign keep = (sx < 9'(SCREEN_W)) && (sy < 8'(SCREEN_H)) && (in_color != TRANSPARENT_COLOR);
`else
  assign keep = (sx < 9'(SCREEN_W)) && (sy < 8'(SCREEN_H));
`endif

  assign wr_entry = {keep, in_last, sx[7:0], sy[6:0], in_color};

  always_comb begin
    state_d      = state_q;
    latch_origin = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (push) begin
          latch_origin = 1'b1;
          if (!in_last) state_d = StActive;
        end
      end
      StActive: begin
        if (push && in_last) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      origin_x_q <= '0;
      origin_y_q <= '0;
    end else begin
      state_q <= state_d;
      if (latch_origin) begin
        origin_x_q <= origin_x;
        origin_y_q <= origin_y;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Remember the last head so the plot coordinates hold steady once the queue empties.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_x_q     <= '0;
      last_y_q     <= '0;
      last_color_q <= '0;
      done_q       <= 1'b0;
      drop_q       <= '0;
    end else begin
      if (!empty) begin
        last_x_q     <= head[17:10];
        last_y_q     <= head[9:3];
        last_color_q <= head[2:0];
      end
      done_q <= pop && head_last;
      if (push && !keep && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;
    end
  end

  assign vga_x      = empty ? last_x_q     : head[17:10];
  assign vga_y      = empty ? last_y_q     : head[9:3];
  assign vga_color  = empty ? last_color_q : head[2:0];
  assign vga_plot   = !empty && head_keep;
  assign done       = done_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_sprite_blit_sink.sv
// Directed bench for sprite_blit_sink: plot order, clipping, transparency, back-pressure, reset.
module tb_sprite_blit_sink;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_x;
  logic [2:0] in_y;
  logic [2:0] in_color;
  logic       in_last;
  logic [7:0] origin_x;
  logic [6:0] origin_y;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_color;
  logic       vga_plot;
  logic       vga_ready;
  logic       done;
  logic [7:0] drop_count;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int acc_cnt  = 0;
  int exp_drop = 0;
  int exp_done = 0;
  logic [17:0] plots [$];
  logic [17:0] exp_q [$];

  sprite_blit_sink dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_color   (in_color),
    .in_last    (in_last),
    .origin_x   (origin_x),
    .origin_y   (origin_y),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_color  (vga_color),
    .vga_plot   (vga_plot),
    .vga_ready  (vga_ready),
    .done       (done),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      if (vga_plot && vga_ready) plots.push_back({vga_x, vga_y, vga_color});
      if (done) done_cnt++;
      if (in_valid && in_ready) acc_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] pk(input int x, input int y, input int c);
    return {8'(x), 7'(y), 3'(c)};
  endfunction

  task automatic send_beat(input int x, input int y, input int c, input bit last);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_x     = 4'(x);
    in_y     = 3'(y);
    in_color = 3'(c);
    in_last  = last;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (15) @(posedge clk);
    #1;
  endtask

  task automatic cmp_plots(input string tag);
    check({tag, "_cnt"}, plots.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < plots.size()) check($sformatf("%s_%0d", tag, i), 32'(plots[i]), 32'(exp_q[i]));
    plots.delete();
    exp_q.delete();
  endtask

  task automatic set_origin(input int x, input int y);
    origin_x = 8'(x);
    origin_y = 7'(y);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0; in_color = '0; in_last = 1'b0;
    origin_x = '0; origin_y = '0; vga_ready = 1'b1;
    @(negedge clk);
    check("rst_in_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_plot", 32'(vga_plot), 32'd0);
    check("rst_xyc", {vga_x, vga_y, vga_color}, 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);
    @(posedge clk); #1;

    // 1: basic 2x2 sprite
    set_origin(10, 20);
    send_beat(0, 0, 1, 0); send_beat(1, 0, 2, 0); send_beat(0, 1, 3, 0); send_beat(1, 1, 4, 1);
    drain();
    exp_q = '{pk(10, 20, 1), pk(11, 20, 2), pk(10, 21, 3), pk(11, 21, 4)};
    cmp_plots("t1");
    exp_done = 1;
    check("t1_done", done_cnt, exp_done);
    check("t1_drop", 32'(drop_count), exp_drop);

    // 2: clipping at the bottom-right corner
    set_origin(159, 119);
    send_beat(0, 0, 1, 0); send_beat(1, 0, 2, 0); send_beat(0, 1, 3, 0); send_beat(1, 1, 4, 1);
    drain();
    exp_q = '{pk(159, 119, 1)};
    cmp_plots("t2");
    exp_drop += 3; exp_done++;
    check("t2_drop", 32'(drop_count), exp_drop);
    check("t2_done", done_cnt, exp_done);

    // 3: transparent key color
    set_origin(40, 50);
    send_beat(0, 0, 0, 0); send_beat(1, 0, 5, 0); send_beat(0, 1, 0, 0); send_beat(1, 1, 6, 1);
    drain();
`ifdef SPRITE_TRANSPARENCY_EN
    exp_q = '{pk(41, 50, 5), pk(41, 51, 6)};
    exp_drop += 2;
`else
    exp_q = '{pk(40, 50, 0), pk(41, 50, 5), pk(40, 51, 0), pk(41, 51, 6)};
`endif
    cmp_plots("t3");
    exp_done++;
    check("t3_drop", 32'(drop_count), exp_drop);
    check("t3_done", done_cnt, exp_done);

    // 4: back-pressure with 10 beats
    set_origin(30, 40);
    vga_ready = 1'b0;
    acc_cnt = 0;
    for (int i = 0; i < 4; i++) send_beat(i, 0, (i % 7) + 1, 0);
    in_valid = 1'b1; in_x = 4'd4; in_y = 3'd0; in_color = 3'd5; in_last = 1'b0;
    repeat (3) @(negedge clk);
    check("t4_full_ready", 32'(in_ready), 32'd0);
    check("t4_acc_stall", acc_cnt, 32'd4);
    check("t4_no_plot", plots.size(), 32'd0);
    @(posedge clk); #1;
    vga_ready = 1'b1;
    for (int i = 4; i < 10; i++) send_beat(i, 0, (i % 7) + 1, i == 9);
    drain();
    for (int i = 0; i < 10; i++) exp_q.push_back(pk(30 + i, 40, (i % 7) + 1));
    cmp_plots("t4");
    exp_done++;
    check("t4_acc", acc_cnt, 32'd10);
    check("t4_done", done_cnt, exp_done);

    // 5: origin changes mid-sprite are ignored; single-beat sprites stay idle
    set_origin(10, 10);
    send_beat(0, 0, 1, 0);
    set_origin(50, 50);
    send_beat(1, 0, 2, 0); send_beat(2, 0, 3, 1);
    send_beat(0, 0, 7, 1);
    set_origin(60, 5);
    send_beat(1, 1, 6, 1);
    drain();
    exp_q = '{pk(10, 10, 1), pk(11, 10, 2), pk(12, 10, 3), pk(50, 50, 7), pk(61, 6, 6)};
    cmp_plots("t5");
    exp_done += 3;
    check("t5_done", done_cnt, exp_done);

    // 6: reset with entries queued
    set_origin(159, 0);
    vga_ready = 1'b0;
    send_beat(0, 0, 1, 0); send_beat(1, 0, 2, 0); send_beat(2, 0, 3, 0);
    @(negedge clk);
    check("t6_pre_drop", 32'(drop_count), exp_drop + 2);
    check("t6_pre_plot", 32'(vga_plot), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("t6_plot", 32'(vga_plot), 32'd0);
    check("t6_done", 32'(done), 32'd0);
    check("t6_drop", 32'(drop_count), 32'd0);
    check("t6_xyc", {vga_x, vga_y, vga_color}, 32'd0);
    @(posedge clk); #1;
    vga_ready = 1'b1;
    drain();
    cmp_plots("t6");
    check("t6_done_total", done_cnt, exp_done);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
